// File: rtl/reg_bcd_display.sv
// reg_bcd_display: selects one register channel per request and converts it
// to NDIG BCD digits with a bit-serial shift-add-3 loop, driving NDIG
// active-low 7-segment displays and flagging values that need more digits.
// Optional feature macro: RBD_LEADING_ZERO_BLANK_EN (blank leading zero digits).
module reg_bcd_display #(
  parameter int WIDTH = 16,
  parameter int NDIG  = 5,
  parameter int NCH   = 8,
  parameter int SELW  = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NCH*WIDTH-1:0]  val_bus,
  input  logic [SELW-1:0]       sel,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*NDIG-1:0]     bcd,
  output logic [7*NDIG-1:0]     hex
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(NDIG);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Digits are scanned from the top so a zero is blanked only while every
  // digit above it is also zero; digit 0 is always shown.
  function automatic logic [7*NDIG-1:0] encode(input logic [4*NDIG-1:0] v);
    logic [7*NDIG-1:0] h;
`ifdef RBD_LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    h = '1;
    for (int unsigned k = 0; k < NDIG; k++) begin
      int unsigned i;
      i = NDIG - 1 - k;
      h[7*i +: 7] = seg7(v[4*i +: 4]);
`ifdef RBD_LEADING_ZERO_BLANK_EN
      if (v[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead && (i != 0)) h[7*i +: 7] = '1;
`endif
    end
    return h;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t                state, state_nx;
  logic [WIDTH-1:0]      shreg, shreg_sh, chan_val;
  logic [4*NDIG-1:0]     acc, acc_adj, acc_sh;
  logic [CW-1:0]         bitcnt;
  logic                  ovf_nx;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Channel select; out-of-range sel falls through to zero.
  always_comb begin
    chan_val = '0;
    for (int unsigned c = 0; c < NCH; c++)
      if (sel == SELW'(c)) chan_val = val_bus[c*WIDTH +: WIDTH];
  end

  // One double-dabble step: add 3 to digits >= 5, then shift {acc,shreg} left.
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < NDIG; i++)
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    acc_sh   = {acc_adj[4*NDIG-2:0], shreg[WIDTH-1]};
    shreg_sh = {shreg[WIDTH-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_SHIFT;
      S_SHIFT: if (bitcnt == '0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath. Results are written on the final shift edge straight from the
  // step logic, so bcd/hex/ovf are already valid in the cycle done is high.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      shreg  <= '0;
      acc    <= '0;
      bitcnt <= '0;
      ovf_nx <= 1'b0;
      ovf    <= 1'b0;
      bcd    <= '0;
      hex    <= encode('0);
    end else begin
      case (state)
        S_IDLE: if (start) begin
          shreg <= chan_val;
          acc   <= '0;
        end
        S_LOAD: begin
          ovf_nx <= (64'(shreg) >= LIMIT);
          bitcnt <= CW'(WIDTH - 1);
        end
        S_SHIFT: begin
          acc    <= acc_sh;
          shreg  <= shreg_sh;
          bitcnt <= bitcnt - 1'b1;
          if (bitcnt == '0) begin
            bcd <= acc_sh;
            hex <= encode(acc_sh);
            ovf <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bcd_display.sv
// Self-checking bench for reg_bcd_display: arithmetic reference model
// (modulo / divide by ten, lookup table for segments) and random stimulus.
module tb_reg_bcd_display;

  logic         clock = 1'b0;
  logic         resetn, start, start4;
  logic [127:0] val_bus, val_bus4;
  logic [2:0]   sel, sel4;
  logic         busy, done, ovf, busy4, done4, ovf4;
  logic [19:0]  bcd;
  logic [34:0]  hex;
  logic [15:0]  bcd4;
  logic [27:0]  hex4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  reg_bcd_display #(.WIDTH(16), .NDIG(5), .NCH(8), .SELW(3)) u_dut (
    .clock(clock), .resetn(resetn), .val_bus(val_bus), .sel(sel), .start(start),
    .busy(busy), .done(done), .ovf(ovf), .bcd(bcd), .hex(hex));

  reg_bcd_display #(.WIDTH(16), .NDIG(4), .NCH(8), .SELW(3)) u_dut4 (
    .clock(clock), .resetn(resetn), .val_bus(val_bus4), .sel(sel4), .start(start4),
    .busy(busy4), .done(done4), .ovf(ovf4), .bcd(bcd4), .hex(hex4));

  // ---------------- reference model ----------------
  function automatic logic [6:0] m_seg(input int unsigned d);
    logic [6:0] tbl [10];
    tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return tbl[d];
  endfunction

  function automatic int unsigned m_pow10(input int unsigned n);
    int unsigned p = 1;
    for (int k = 0; k < int'(n); k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] m_bcd(input int unsigned v, input int unsigned nd);
    logic [31:0] r = '0;
    int unsigned x = v % m_pow10(nd);
    for (int i = 0; i < int'(nd); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [55:0] m_hex(input int unsigned v, input int unsigned nd);
    logic [55:0] r = '1;
    int unsigned m = v % m_pow10(nd);
    for (int i = 0; i < int'(nd); i++) begin
      r[7*i +: 7] = m_seg((m / m_pow10(i)) % 10);
`ifdef RBD_LEADING_ZERO_BLANK_EN
      if (i > 0 && m < m_pow10(i)) r[7*i +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  // Drives one request on the 5-digit instance and waits (bounded) for done.
  // lat counts sampling points after the accept edge; 1 = first cycle after it.
  task automatic do_conv(input int unsigned ch, input logic [15:0] value, input bit scramble,
                         output int lat, output logic [19:0] obcd, output logic [34:0] ohex,
                         output logic oovf);
    @(negedge clock);
    val_bus[ch*16 +: 16] = value;
    sel   = 3'(ch);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
      if (scramble && lat == 5) begin
        val_bus = {$urandom, $urandom, $urandom, $urandom};
        sel     = 3'($urandom);
      end
    end
    obcd = bcd; ohex = hex; oovf = ovf;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [55:0] eh;
    resetn = 1'b0; start = 1'b0; start4 = 1'b0; sel = '0; sel4 = '0;
    val_bus = '0; val_bus4 = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    eh = m_hex(0, 5);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_checks++; if (bcd !== 20'h00000) begin n_fail++; $display("FAIL reset_bcd got %h want 00000", bcd); end
    n_checks++; if (hex !== eh[34:0]) begin n_fail++; $display("FAIL reset_hex got %b want %b", hex, eh[34:0]); end
    n_checks++; if (hex[6:0] !== 7'b0000001) begin n_fail++; $display("FAIL reset_hex0 got %b want 0000001", hex[6:0]); end
    resetn = 1'b1;
  endtask

  task automatic test_latency();
    int n;
    logic [31:0] eb;
    logic [55:0] eh;
    @(negedge clock);
    val_bus[3*16 +: 16] = 16'd1234; sel = 3'd3; start = 1'b1;
    @(posedge clock);
    for (n = 1; n <= 19; n++) begin
      @(negedge clock);
      if (n == 1) begin
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy got %b want 1", busy); end
      end
      n_checks++;
      if (done !== (n == 18)) begin n_fail++; $display("FAIL lat_done cycle %0d got %b want %b", n, done, n == 18); end
      if (n == 18) begin
        eb = m_bcd(1234, 5); eh = m_hex(1234, 5);
        n_checks++; if (bcd !== 20'h01234) begin n_fail++; $display("FAIL lat_bcd got %h want 01234", bcd); end
        n_checks++; if (bcd !== eb[19:0]) begin n_fail++; $display("FAIL lat_bcd_model got %h want %h", bcd, eb[19:0]); end
        n_checks++; if (hex[13:0] !== {7'b0000110, 7'b1001100}) begin n_fail++; $display("FAIL lat_hex_lo got %b want 00001101001100", hex[13:0]); end
        n_checks++; if (hex !== eh[34:0]) begin n_fail++; $display("FAIL lat_hex got %b want %b", hex, eh[34:0]); end
      end
    end
  endtask

  task automatic test_random();
    int unsigned fixed [6] = '{0, 9, 10, 65535, 9999, 10000};
    int unsigned v, ch;
    int lat;
    logic [19:0] ob; logic [34:0] oh; logic oo;
    logic [31:0] eb; logic [55:0] eh;
    for (int it = 0; it < 22; it++) begin
      v  = (it < 6) ? fixed[it] : $urandom_range(0, 65535);
      ch = $urandom_range(0, 7);
      val_bus = {$urandom, $urandom, $urandom, $urandom};
      do_conv(ch, 16'(v), 1'b1, lat, ob, oh, oo);
      eb = m_bcd(v, 5); eh = m_hex(v, 5);
      n_checks++; if (lat != 18) begin n_fail++; $display("FAIL rnd_latency v=%0d got %0d want 18", v, lat); end
      n_checks++; if (ob !== eb[19:0]) begin n_fail++; $display("FAIL rnd_bcd v=%0d got %h want %h", v, ob, eb[19:0]); end
      n_checks++; if (oh !== eh[34:0]) begin n_fail++; $display("FAIL rnd_hex v=%0d got %b want %b", v, oh, eh[34:0]); end
      n_checks++; if (oo !== 1'b0) begin n_fail++; $display("FAIL rnd_ovf v=%0d got %b want 0", v, oo); end
    end
  endtask

  task automatic test_overflow();
    int unsigned vals [7] = '{65535, 9999, 10000, 0, 12345, 4321, 0};
    int unsigned v;
    int lat;
    logic [31:0] eb; logic [55:0] eh;
    vals[6] = $urandom_range(0, 65535);
    for (int it = 0; it < 7; it++) begin
      v = vals[it];
      @(negedge clock);
      val_bus4[5*16 +: 16] = 16'(v); sel4 = 3'd5; start4 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start4 = 1'b0;
      lat = 1;
      while (!done4 && lat < 40) begin @(negedge clock); lat++; end
      eb = m_bcd(v, 4); eh = m_hex(v, 4);
      n_checks++; if (lat != 18) begin n_fail++; $display("FAIL ovf_latency v=%0d got %0d want 18", v, lat); end
      n_checks++; if (bcd4 !== eb[15:0]) begin n_fail++; $display("FAIL ovf_bcd v=%0d got %h want %h", v, bcd4, eb[15:0]); end
      n_checks++; if (hex4 !== eh[27:0]) begin n_fail++; $display("FAIL ovf_hex v=%0d got %b want %b", v, hex4, eh[27:0]); end
      n_checks++; if (ovf4 !== (v >= 10000)) begin n_fail++; $display("FAIL ovf_flag v=%0d got %b want %b", v, ovf4, v >= 10000); end
      if (it == 0) begin
        n_checks++; if (bcd4 !== 16'h5535) begin n_fail++; $display("FAIL ovf_65535 got %h want 5535", bcd4); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, ndone = 0;
    @(negedge clock);
    val_bus[1*16 +: 16] = 16'd42; sel = 3'd1; start = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 5) val_bus[1*16 +: 16] = 16'd7;
      if (done) begin
        ndone++;
        if (d1 < 0) begin
          d1 = n;
          n_checks++; if (bcd !== 20'h00042) begin n_fail++; $display("FAIL b2b_first got %h want 00042", bcd); end
        end else if (d2 < 0) begin
          d2 = n;
          n_checks++; if (bcd !== 20'h00007) begin n_fail++; $display("FAIL b2b_second got %h want 00007", bcd); end
        end
      end
      if (n == 25) begin
        n_checks++; if (bcd !== 20'h00042) begin n_fail++; $display("FAIL b2b_hold got %h want 00042", bcd); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy); end
      end
      if (n == 37) start = 1'b0;
      if (n == 39) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", busy); end
      end
    end
    n_checks++; if (d1 != 18) begin n_fail++; $display("FAIL b2b_d1 got %0d want 18", d1); end
    n_checks++; if (d2 - d1 != 19) begin n_fail++; $display("FAIL b2b_period got %0d want 19", d2 - d1); end
    n_checks++; if (ndone != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", ndone); end
  endtask

  task automatic test_reset_abort();
    int ndone = 0, lat;
    int unsigned v;
    logic [19:0] ob; logic [34:0] oh; logic oo;
    logic [31:0] eb; logic [55:0] eh;
    @(negedge clock);
    val_bus[2*16 +: 16] = 16'd54321; sel = 3'd2; start = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clock);
      if (n == 1) start = 1'b0;
      if (done) ndone++;
    end
    resetn = 1'b0;
    @(negedge clock);
    eh = m_hex(0, 5);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_checks++; if (bcd !== 20'h00000) begin n_fail++; $display("FAIL abort_bcd got %h want 00000", bcd); end
    n_checks++; if (hex !== eh[34:0]) begin n_fail++; $display("FAIL abort_hex got %b want %b", hex, eh[34:0]); end
    resetn = 1'b1;
    for (int n = 0; n < 25; n++) begin
      if (done) ndone++;
      @(negedge clock);
    end
    n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL abort_nodone got %0d want 0", ndone); end
    v = $urandom_range(0, 65535);
    do_conv(6, 16'(v), 1'b0, lat, ob, oh, oo);
    eb = m_bcd(v, 5); eh = m_hex(v, 5);
    n_checks++; if (lat != 18) begin n_fail++; $display("FAIL abort_relat got %0d want 18", lat); end
    n_checks++; if (ob !== eb[19:0]) begin n_fail++; $display("FAIL abort_rebcd v=%0d got %h want %h", v, ob, eb[19:0]); end
  endtask

  task automatic test_small_values();
    int lat;
    logic [19:0] ob; logic [34:0] oh; logic oo;
    logic [55:0] eh;
    do_conv(0, 16'd7, 1'b0, lat, ob, oh, oo);
    eh = m_hex(7, 5);
    n_checks++; if (oh[6:0] !== 7'b0001111) begin n_fail++; $display("FAIL seven_d0 got %b want 0001111", oh[6:0]); end
    n_checks++; if (oh !== eh[34:0]) begin n_fail++; $display("FAIL seven_hex got %b want %b", oh, eh[34:0]); end
    do_conv(0, 16'd0, 1'b0, lat, ob, oh, oo);
    eh = m_hex(0, 5);
    n_checks++; if (oh !== eh[34:0]) begin n_fail++; $display("FAIL zero_hex got %b want %b", oh, eh[34:0]); end
    n_checks++; if (ob !== 20'h00000) begin n_fail++; $display("FAIL zero_bcd got %h want 00000", ob); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_random();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_small_values();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
